cache_wt2: RTL
==============

# cache_wt2

Parametrised 2-way set-associative, write-through, no-write-allocate cache controller with multi-word line refill. It is the next generation of the direct-mapped CACHE/TABLE pair. It sits between the CPU data port and the main RAM model. It owns tag/valid/LRU state and the data array, and talks to RAM over a held-request/ack handshake. Hit/miss statistics are kept in saturating counters.

## Interface
- AW, 16: word-address width (word-addressed, not byte-addressed)
- DW, 32: data word width
- SETS_LOG2, 2: log2 of set count
- WORDS_LOG2, 2: log2 of words per line; tag width = AW-SETS_LOG2-WORDS_LOG2 (must be >=1)
- CW, 16: statistics counter width
- clk  in  1  system clock; all logic on rising edge
- clr  in  1  reset, synchronous, active-high
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data, valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- hit  out  1  pulses with cpu_ready when the access hit
- mem_rd  out  1  RAM read request, held until ack
- mem_wr  out  1  RAM write request, held until ack
- mem_addr  out  AW  RAM word address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM completes the current request this cycle
- hit_cnt  out  CW  saturating count of hits
- miss_cnt  out  CW  saturating count of misses

## Operation
- Address split: word offset = cpu_addr[WORDS_LOG2-1:0]; set = next SETS_LOG2 bits; tag = the remainder.
- Per set, per way: valid bit, tag, line data. Per set: one LRU bit naming the least-recently-used way.
- States: IDLE, WRITE, REFILL, RESP.
- Accept: in IDLE, on an edge with cpu_req=1, latch addr/we/wdata and perform the tag compare. The CPU does not need to hold its inputs afterwards. cpu_req outside IDLE is ignored.
- Read hit (IDLE): load cpu_rdata from the matching way. Pulse cpu_ready and hit next cycle. Set LRU to the other way. Increment hit_cnt. Stay in IDLE.
- Read miss: increment miss_cnt and go to REFILL.
  - Victim: the first invalid way (way0 before way1); if both ways are valid, the LRU way.
  - Clear the victim's valid bit on entry.
  - Read WORDS words with mem_addr = {tag,set,beat}, beat 0..WORDS-1 ascending.
  - On each mem_ack, write mem_rdata into the victim line and advance beat. When beat equals the requested offset, also capture the word into cpu_rdata.
  - After the last ack: set valid and tag, set LRU to the other way, go to RESP.
  - RESP: pulse cpu_ready (hit=0), then IDLE.
- Write (hit or miss): go to WRITE and drive mem_wr, mem_addr = latched addr, mem_wdata = latched data.
  - On a hit, update the cached word and LRU at the accept edge, and increment hit_cnt.
  - On a miss, cache state is unchanged (no allocate); increment miss_cnt.
  - On mem_ack: pulse cpu_ready, with hit = the latched hit status, and return to IDLE.
- Counters saturate at all-ones. They are cleared only by clr.

## Timing
- Reset values:
  - all outputs 0;
  - every valid bit 0 and every LRU bit 0;
  - beat counter 0, state IDLE.
- Data array contents are not reset.
- clr overrides everything in the same edge, including mid-refill and mid-write. After a clr during refill, the victim line is left invalid and mem_rd drops on the next cycle.
- Read-hit latency: cpu_ready one cycle after the accept edge. Back-to-back hits are accepted every 2 cycles.
- Read-miss latency: 1 + sum of per-beat ack waits + 1 (RESP) cycles.
- Memory handshake:
  - at most one of mem_rd/mem_wr is high at a time;
  - address and data stay stable while the request is high;
  - one transfer per cycle in which mem_ack=1 and a request is high.
- A mem_ack in the same cycle a request is first asserted is legal, giving 1-cycle beats.
- mem_rd stays high between refill beats; its address changes only on the ack edge.
- mem_ack while idle is ignored.
- cpu_ready and hit are each exactly one cycle wide. cpu_rdata holds its value until the next read completes.

## Test plan
Configuration for all scenarios: default parameters, RAM model with mem[a] = a*3 and a 1-cycle ack delay.

- Read 0x0013 after reset -> mem_rd at 0x0010..0x0013 in order; cpu_rdata = 0x39, hit=0, miss_cnt=1. Then read 0x0010 -> cpu_ready 1 cycle after accept, cpu_rdata = 0x30, hit=1, no mem_rd.
- After the above, write 0x0011 with 0xDEADBEEF -> mem_wr at 0x0011 with 0xDEADBEEF, then hit=1 with cpu_ready. Then read 0x0011 -> 0xDEADBEEF, hit=1, no RAM traffic.
- Write miss to 0x0050 with 0x55 -> one mem_wr, hit=0. Then read 0x0050 -> miss and 4-beat refill returning 0x55 (no write-allocate).
- LRU: read 0x0010, 0x0110, 0x0010, then 0x0210 (all set 0) -> 0x0110's way is evicted. Then read 0x0010 -> hit; read 0x0110 -> miss.
- clr asserted on the edge of the third refill beat of a read of 0x0020 -> next cycle mem_rd=0, cpu_ready=0, counters=0. Re-read 0x0020 -> full 4-beat refill, hit=0.
- Hold cpu_req=1 with changing addresses during a refill -> requests ignored until IDLE; only the latched address is served.

Source files
------------

// File: rtl/cache_wt2.sv
`default_nettype none
// ============================================================================
//  Module   : cache_wt2
//  Brief    : 2-way set-associative write-through, no-write-allocate cache
//             controller with multi-word line refill and hit/miss counters.
//  Revision : 1.0
// ============================================================================
module cache_wt2 #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int SETS_LOG2  = 2,
    parameter int WORDS_LOG2 = 2,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    output logic          hit,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [CW-1:0] hit_cnt,
    output logic [CW-1:0] miss_cnt
);

    localparam int c_TW   = AW - SETS_LOG2 - WORDS_LOG2;
    localparam int c_SETS = 1 << SETS_LOG2;
    localparam int c_IW   = SETS_LOG2 + WORDS_LOG2;
    localparam logic [WORDS_LOG2-1:0] c_LAST = '1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WRITE  = 2'd1;
    localparam logic [1:0] c_REFILL = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_valid [0:1][0:c_SETS-1];
    logic                  r_lru   [0:c_SETS-1];
    logic [c_TW-1:0]       r_tag   [0:1][0:c_SETS-1];
    logic [DW-1:0]         r_data  [0:1][0:(1<<c_IW)-1];
    logic [AW-1:0]         r_addr;
    logic                  r_way;
    logic                  r_whit;
    logic [WORDS_LOG2-1:0] r_beat;

    logic [c_TW-1:0]       w_tag;
    logic [SETS_LOG2-1:0]  w_set;
    logic [WORDS_LOG2-1:0] w_off;
    logic [c_TW-1:0]       w_rtag;
    logic [SETS_LOG2-1:0]  w_rset;
    logic [WORDS_LOG2-1:0] w_roff;
    logic [WORDS_LOG2-1:0] w_beat_nx;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic                  w_hway;
    logic                  w_victim;
    logic                  w_accept;
    logic [DW-1:0]         w_hword;
    logic [CW-1:0]         w_hit_cnt_nx;
    logic [CW-1:0]         w_miss_cnt_nx;

    assign w_tag  = cpu_addr[AW-1 -: c_TW];
    assign w_set  = cpu_addr[WORDS_LOG2 +: SETS_LOG2];
    assign w_off  = cpu_addr[WORDS_LOG2-1:0];
    assign w_rtag = r_addr[AW-1 -: c_TW];
    assign w_rset = r_addr[WORDS_LOG2 +: SETS_LOG2];
    assign w_roff = r_addr[WORDS_LOG2-1:0];
    assign w_beat_nx = r_beat + WORDS_LOG2'(1);

    assign w_hit0 = r_valid[0][w_set] && (r_tag[0][w_set] == w_tag);
    assign w_hit1 = r_valid[1][w_set] && (r_tag[1][w_set] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;
    assign w_hway = w_hit1;
    assign w_hword = r_data[w_hway][{w_set, w_off}];

    // Fill an empty way first; only evict when the set is full.
    assign w_victim = !r_valid[0][w_set] ? 1'b0 :
                      !r_valid[1][w_set] ? 1'b1 : r_lru[w_set];

    // The cycle carrying a hit's ready pulse is not an accept slot.
    assign w_accept = (r_state == c_IDLE) && cpu_req && !cpu_ready;

    assign w_hit_cnt_nx  = (hit_cnt  == '1) ? hit_cnt  : hit_cnt  + CW'(1);
    assign w_miss_cnt_nx = (miss_cnt == '1) ? miss_cnt : miss_cnt + CW'(1);

    // Line storage and tags carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (w_accept && cpu_we && w_hit) begin
                r_data[w_hway][{w_set, w_off}] <= cpu_wdata;
            end
            if ((r_state == c_REFILL) && mem_ack) begin
                r_data[r_way][{w_rset, r_beat}] <= mem_rdata;
                if (r_beat == c_LAST) begin
                    r_tag[r_way][w_rset] <= w_rtag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_IDLE;
            r_beat    <= '0;
            r_addr    <= '0;
            r_way     <= 1'b0;
            r_whit    <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            for (int s = 0; s < c_SETS; s++) begin
                r_valid[0][s] <= 1'b0;
                r_valid[1][s] <= 1'b0;
                r_lru[s]      <= 1'b0;
            end
        end else begin
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_addr <= cpu_addr;
                        r_whit <= w_hit;
                        if (cpu_we) begin
                            mem_wr    <= 1'b1;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            r_state   <= c_WRITE;
                            if (w_hit) begin
                                r_lru[w_set] <= ~w_hway;
                                hit_cnt      <= w_hit_cnt_nx;
                            end else begin
                                miss_cnt <= w_miss_cnt_nx;
                            end
                        end else if (w_hit) begin
                            cpu_rdata    <= w_hword;
                            cpu_ready    <= 1'b1;
                            hit          <= 1'b1;
                            r_lru[w_set] <= ~w_hway;
                            hit_cnt      <= w_hit_cnt_nx;
                        end else begin
                            miss_cnt                <= w_miss_cnt_nx;
                            r_way                   <= w_victim;
                            r_valid[w_victim][w_set] <= 1'b0;
                            r_beat                  <= '0;
                            mem_rd                  <= 1'b1;
                            mem_addr                <= {cpu_addr[AW-1:WORDS_LOG2], {WORDS_LOG2{1'b0}}};
                            r_state                 <= c_REFILL;
                        end
                    end
                end
                c_WRITE: begin
                    if (mem_ack) begin
                        mem_wr    <= 1'b0;
                        cpu_ready <= 1'b1;
                        hit       <= r_whit;
                        r_state   <= c_IDLE;
                    end
                end
                c_REFILL: begin
                    if (mem_ack) begin
                        if (r_beat == w_roff) begin
                            cpu_rdata <= mem_rdata;
                        end
                        if (r_beat == c_LAST) begin
                            mem_rd                <= 1'b0;
                            r_valid[r_way][w_rset] <= 1'b1;
                            r_lru[w_rset]         <= ~r_way;
                            r_beat                <= '0;
                            cpu_ready             <= 1'b1;
                            r_state               <= c_RESP;
                        end else begin
                            r_beat   <= w_beat_nx;
                            mem_addr <= {r_addr[AW-1:WORDS_LOG2], w_beat_nx};
                        end
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
